// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: sequencer state
// encoding, reset fetch address and the sequential-PC helper.
package mips_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/target_calc.sv
// Forms the jump or branch destination from the redirecting instruction's
// address; both kinds are relative to the delay-slot address (pc+4).
module target_calc
    import mips_pkg::*;
(
    input  logic        redir_jump,
    input  logic [31:0] redir_pc,
    input  logic [25:0] jump_index,
    input  logic [15:0] branch_off,
    output logic [31:0] target
);

    logic [31:0] link_s;
    logic [31:0] off_ext_s;

    assign link_s    = pc_inc(redir_pc);
    assign off_ext_s = {{14{branch_off[15]}}, branch_off, 2'b00};

    // Select region jump or signed branch displacement
    always_comb begin
        target = 32'h0000_0000;
        if (redir_jump) begin
            target = {link_s[31:28], jump_index, 2'b00};
        end else begin
            target = link_s + off_ext_s;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: holds the PC, issues instruction-memory requests,
// tracks one pending control-flow redirect and counts accepted fetches.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir_valid,
    input  logic        redir_jump,
    input  logic        redir_taken,
    input  logic [31:0] redir_pc,
    input  logic [25:0] jump_index,
    input  logic [15:0] branch_off,
    input  logic        stall,
    input  logic        halt,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [15:0] fetch_cnt,
    output logic        halted
);

    logic [1:0]  state_r;
    logic [1:0]  next_state_s;
    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic        pend_valid_r;
    logic [31:0] pend_target_r;
    logic [15:0] cnt_r;
    logic        req_r;
    logic        halted_r;
    logic [31:0] new_target_s;
    logic        redir_hit_s;
    logic        accept_s;
    logic        consume_s;

    target_calc u_target_calc (
        .redir_jump (redir_jump),
        .redir_pc   (redir_pc),
        .jump_index (jump_index),
        .branch_off (branch_off),
        .target     (new_target_s)
    );

    assign redir_hit_s = redir_valid & (redir_jump | redir_taken);
    assign accept_s    = (state_r == ST_FETCH) & imem_ack;
    // A stalled accept still advances sequentially; the redirect waits for a clean accept
    assign consume_s   = accept_s & ~stall;

    // Next fetch address: fresh redirect, then pending one, then sequential
    always_comb begin
        next_pc_s = pc_inc(pc_r);
        if (consume_s && redir_hit_s) begin
            next_pc_s = new_target_s;
        end else if (consume_s && pend_valid_r) begin
            next_pc_s = pend_target_r;
        end else begin
            next_pc_s = pc_inc(pc_r);
        end
    end

    // State transitions; halt outranks stall everywhere
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_BOOT:  next_state_s = halt ? ST_HALT : ST_FETCH;
            ST_FETCH: begin
                if (halt) begin
                    next_state_s = ST_HALT;
                end else if (stall) begin
                    next_state_s = ST_STALL;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_STALL: begin
                if (halt) begin
                    next_state_s = ST_HALT;
                end else if (!stall) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_STALL;
                end
            end
            ST_HALT:  next_state_s = ST_HALT;
            default:  next_state_s = ST_BOOT;
        endcase
    end

    // Sequencer state, PC, pending redirect, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_PC;
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h0000_0000;
            cnt_r         <= 16'h0000;
            req_r         <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            req_r    <= (next_state_s == ST_FETCH);
            halted_r <= (next_state_s == ST_HALT);
            if (accept_s) begin
                pc_r  <= next_pc_s;
                cnt_r <= cnt_r + 16'd1;
            end else begin
                pc_r  <= pc_r;
                cnt_r <= cnt_r;
            end
            if (consume_s) begin
                pend_valid_r <= 1'b0;
            end else if (redir_hit_s) begin
                pend_valid_r  <= 1'b1;
                pend_target_r <= new_target_s;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = pc_r;
    assign fetch_cnt = cnt_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redir_valid = 1'b0;
    logic        redir_jump = 1'b0;
    logic        redir_taken = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic [25:0] jump_index = 26'h0;
    logic [15:0] branch_off = 16'h0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [15:0] fetch_cnt;
    logic        halted;

    int checks = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redir_valid (redir_valid),
        .redir_jump  (redir_jump),
        .redir_taken (redir_taken),
        .redir_pc    (redir_pc),
        .jump_index  (jump_index),
        .branch_off  (branch_off),
        .stall       (stall),
        .halt        (halt),
        .imem_ack    (imem_ack),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .fetch_cnt   (fetch_cnt),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and pass through BOOT so the DUT sits in FETCH at RESET_PC
    task automatic do_reset();
        redir_valid = 1'b0; redir_jump = 1'b0; redir_taken = 1'b0;
        stall = 1'b0; halt = 1'b0; imem_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || fetch_cnt !== 16'h0 || halted !== 1'b0) begin
            $display("FAIL reset_state req=%b addr=%h cnt=%h halted=%b want 0/00000000/0000/0",
                     imem_req, imem_addr, fetch_cnt, halted);
            failures++;
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            $display("FAIL boot_req actual=%b expected=0", imem_req);
            failures++;
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            $display("FAIL first_fetch req=%b addr=%h want 1/00000000", imem_req, imem_addr);
            failures++;
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h4; exp_addr[1] = 32'h8; exp_addr[2] = 32'hC;
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (imem_addr !== exp_addr[i] || fetch_cnt !== 16'(i + 1) || imem_req !== 1'b1) begin
                $display("FAIL seq_%0d addr=%h cnt=%0d req=%b want %h/%0d/1",
                         i, imem_addr, fetch_cnt, imem_req, exp_addr[i], i + 1);
                failures++;
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_jump();
        do_reset();
        // redirect and ack together: applied on the same edge
        redir_valid = 1'b1; redir_jump = 1'b1; redir_pc = 32'hEFFF_FFFC; jump_index = 26'd7;
        imem_ack = 1'b1;
        step();
        checks++;
        if (imem_addr !== 32'hF000_001C) begin
            $display("FAIL jump_same_edge actual=%h expected=F000001C", imem_addr);
            failures++;
        end
        redir_valid = 1'b0; imem_ack = 1'b0;
        redir_valid = 1'b1; redir_pc = 32'h4FFF_FFFC; jump_index = 26'd23337;
        step();
        redir_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'hF000_001C) begin
            $display("FAIL jump_wait_ack actual=%h expected=F000001C", imem_addr);
            failures++;
        end
        imem_ack = 1'b1;
        step();
        checks++;
        if (imem_addr !== 32'h5001_6CA4) begin
            $display("FAIL jump_pending actual=%h expected=50016CA4", imem_addr);
            failures++;
        end
        step();
        checks++;
        if (imem_addr !== 32'h5001_6CA8) begin
            $display("FAIL jump_pending_cleared actual=%h expected=50016CA8", imem_addr);
            failures++;
        end
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC; jump_index = 26'd1;
        step();
        redir_valid = 1'b0; redir_jump = 1'b0; imem_ack = 1'b0;
        checks++;
        if (imem_addr !== 32'h0000_0004) begin
            $display("FAIL jump_wrap actual=%h expected=00000004", imem_addr);
            failures++;
        end
    endtask

    task automatic test_branch();
        do_reset();
        redir_valid = 1'b1; redir_jump = 1'b0; redir_taken = 1'b1;
        redir_pc = 32'h100; branch_off = 16'hFFFF; imem_ack = 1'b1;
        step();
        checks++;
        if (imem_addr !== 32'h100) begin
            $display("FAIL branch_taken actual=%h expected=00000100", imem_addr);
            failures++;
        end
        redir_taken = 1'b0;
        step();
        checks++;
        if (imem_addr !== 32'h104) begin
            $display("FAIL branch_not_taken actual=%h expected=00000104", imem_addr);
            failures++;
        end
        redir_valid = 1'b0;
        step();
        imem_ack = 1'b0;
        checks++;
        if (imem_addr !== 32'h108 || fetch_cnt !== 16'd3) begin
            $display("FAIL branch_continue addr=%h cnt=%0d want 00000108/3", imem_addr, fetch_cnt);
            failures++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0; stall = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin
            $display("FAIL stall_enter req=%b addr=%h want 0/00000004", imem_req, imem_addr);
            failures++;
        end
        redir_valid = 1'b1; redir_jump = 1'b1; redir_pc = 32'hEFFF_FFFC; jump_index = 26'd7;
        step();
        redir_valid = 1'b0; redir_jump = 1'b0;
        stall = 1'b0;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            $display("FAIL stall_exit req=%b addr=%h want 1/00000004", imem_req, imem_addr);
            failures++;
        end
        imem_ack = 1'b1;
        step();
        checks++;
        if (imem_addr !== 32'hF000_001C || fetch_cnt !== 16'd2) begin
            $display("FAIL stall_redirect addr=%h cnt=%0d want F000001C/2", imem_addr, fetch_cnt);
            failures++;
        end
        stall = 1'b1;
        step();
        checks++;
        if (imem_addr !== 32'hF000_0020 || imem_req !== 1'b0 || fetch_cnt !== 16'd3) begin
            $display("FAIL ack_with_stall addr=%h req=%b cnt=%0d want F0000020/0/3",
                     imem_addr, imem_req, fetch_cnt);
            failures++;
        end
        step();
        checks++;
        if (imem_addr !== 32'hF000_0020 || fetch_cnt !== 16'd3) begin
            $display("FAIL ack_in_stall_ignored addr=%h cnt=%0d want F0000020/3", imem_addr, fetch_cnt);
            failures++;
        end
        stall = 1'b0; imem_ack = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        halt = 1'b1; stall = 1'b1; imem_ack = 1'b1;
        step();
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h4 || fetch_cnt !== 16'd1) begin
            $display("FAIL halt_enter halted=%b req=%b addr=%h cnt=%0d want 1/0/00000004/1",
                     halted, imem_req, imem_addr, fetch_cnt);
            failures++;
        end
        halt = 1'b0; stall = 1'b0;
        repeat (2) step();
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h4) begin
            $display("FAIL halt_sticky halted=%b req=%b addr=%h want 1/0/00000004",
                     halted, imem_req, imem_addr);
            failures++;
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || fetch_cnt !== 16'h0 || imem_addr !== 32'h0 || halted !== 1'b0) begin
            $display("FAIL reset_mid_fetch req=%b cnt=%0d addr=%h halted=%b want 0/0/00000000/0",
                     imem_req, fetch_cnt, imem_addr, halted);
            failures++;
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_cnt !== 16'h0) begin
            $display("FAIL reset_release req=%b addr=%h cnt=%0d want 1/00000000/0",
                     imem_req, imem_addr, fetch_cnt);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_stall();
        test_halt();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, as the first fetch address after reset.
REQ-002 The block SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-004 The block SHALL have port redir_valid  in  1  one-cycle pulse from decode: a redirect is present.
REQ-005 The block SHALL have port redir_jump  in  1  1 = J-type jump, 0 = conditional branch.
REQ-006 The block SHALL have port redir_taken  in  1  branch outcome; ignored when redir_jump=1.
REQ-007 The block SHALL have port redir_pc  in  32  address of the jump/branch instruction.
REQ-008 The block SHALL have port jump_index  in  26  J-type instr_index field.
REQ-009 The block SHALL have port branch_off  in  16  I-type signed immediate.
REQ-010 The block SHALL have port stall  in  1  pipeline hold request.
REQ-011 The block SHALL have port halt  in  1  stop fetching until reset.
REQ-012 The block SHALL have port imem_ack  in  1  instruction memory accepted the current address.
REQ-013 The block SHALL have port imem_req  out  1  fetch request.
REQ-014 The block SHALL have port imem_addr  out  32  fetch address, driven from the PC register.
REQ-015 The block SHALL have port fetch_cnt  out  16  count of accepted fetches.
REQ-016 The block SHALL have port halted  out  1  high in HALT state.

Function
REQ-017 The block SHALL implement states BOOT, FETCH, STALL, HALT.
REQ-018 BOOT: imem_req=0; next state FETCH unconditionally.
REQ-019 FETCH: imem_req=1, imem_addr=pc; request is held stable until imem_ack.
REQ-020 The block SHALL load pc with next_pc on the clock edge where imem_ack=1 in FETCH; latency one cycle.
REQ-021 next_pc SHALL be the pending redirect target if one is pending, else pc+4, mod 2^32.
REQ-022 Jump target SHALL be {(redir_pc+4)[31:28], jump_index, 2'b00}.
REQ-023 Branch target SHALL be (redir_pc+4) + (sign-extended branch_off << 2), mod 2^32.
REQ-024 A redirect SHALL be recorded when redir_valid=1 and (redir_jump=1 or redir_taken=1); not-taken branches SHALL be ignored.
REQ-025 One pending-redirect register SHALL exist; a newer redirect overwrites an unconsumed one; it is cleared when consumed.
REQ-026 redir_valid together with imem_ack in the same cycle SHALL apply the new target immediately on that edge.
REQ-027 FETCH with stall=1 and imem_ack=0 SHALL go to STALL with the request withdrawn; pc unchanged.
REQ-028 FETCH with stall=1 and imem_ack=1 SHALL advance pc, then go to STALL.
REQ-029 STALL: imem_req=0; redirects are still recorded; returns to FETCH the cycle after stall=0.
REQ-030 halt=1 in any state SHALL enter HALT next edge (an ack on that edge still advances pc); HALT exits only by reset.
REQ-031 halt has priority over stall; stall over redirect consumption.
REQ-032 fetch_cnt SHALL increment on every imem_ack while imem_req=1, wrapping 16'hFFFF->0.

Reset
REQ-033 rst_n low SHALL immediately force: state BOOT, pc=RESET_PC, pending cleared, fetch_cnt=0, imem_req=0, halted=0.
REQ-034 Reset during an outstanding fetch SHALL abandon it without advancing pc or counting.

Structure
REQ-035 State encoding and RESET_PC default SHALL live in shared package mips_pkg.
REQ-036 Target formation (REQ-022/023) SHALL be a combinational sub-module target_calc.

Verification
REQ-037 Reset, ack every cycle -> imem_addr 0x0, 0x4, 0x8; fetch_cnt 1,2,3.
REQ-038 Jump redir_pc=0xEFFFFFFC, index=7 -> next address 0xF000001C; redir_pc=0x4FFFFFFC, index=23337 -> 0x50016CA4.
REQ-039 Jump redir_pc=0xFFFFFFFC, index=1 -> 0x00000004 (upper bits from wrapped PC+4).
REQ-040 Branch redir_pc=0x100, off=0xFFFF, taken -> 0x100; taken=0 -> sequential 0x104-line continues unchanged.
REQ-041 Redirect during STALL, then ack -> target fetched after stall drops; ack+stall same cycle -> pc advances, imem_req low next cycle.
REQ-042 rst_n low mid-FETCH with ack withheld -> imem_req low immediately, fetch_cnt=0, first address after release RESET_PC.
